// File: rtl/dma_rd_pkg.sv
// Shared constants for the DMA-read reorder controller: sizing, FSM encodings
// and the bit positions of the sticky error vector.
package dma_rd_pkg;

  localparam int TAG_NUM     = 64;
  localparam int TAG_NUM_LOG = 6;
  localparam int DATA_W      = 256;
  localparam int BEAT_MAX    = 8;
  localparam int BEAT_CNT_W  = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam int ERR_BEAT_OVERFLOW = 0;
  localparam int ERR_STRAY_STORE   = 1;
  localparam int ERR_LAST_MISMATCH = 2;

endpackage

// File: rtl/rsp_skid_fifo.sv
// Two-entry response FIFO between the tag-buffer fetch port and the output
// stream; the head entry is presented combinationally.
module rsp_skid_fifo #(
  parameter int W = dma_rd_pkg::TAG_NUM_LOG + 1 + dma_rd_pkg::DATA_W
) (
  input  logic         dma_clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    // NOTE: every signal gets a default before any condition so no latch is inferred.
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset here because the idle head must read as zero on out_data.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/dma_rd_reorder_ctrl.sv
// Allocates read tags as a ring, snoops the tag buffer's store channel, and
// drains completed tags in allocation order into a valid/ready response stream.
module dma_rd_reorder_ctrl
  import dma_rd_pkg::ST_IDLE, dma_rd_pkg::ST_DRAIN, dma_rd_pkg::BEAT_CNT_W,
         dma_rd_pkg::ERR_BEAT_OVERFLOW, dma_rd_pkg::ERR_STRAY_STORE,
         dma_rd_pkg::ERR_LAST_MISMATCH;
#(
  parameter int TAG_NUM     = dma_rd_pkg::TAG_NUM,
  parameter int TAG_NUM_LOG = dma_rd_pkg::TAG_NUM_LOG,
  parameter int DATA_W      = dma_rd_pkg::DATA_W,
  parameter int BEAT_MAX    = dma_rd_pkg::BEAT_MAX
) (
  input  logic                   dma_clk,
  input  logic                   rst_n,
  input  logic                   alloc_req,
  output logic                   alloc_gnt,
  output logic [TAG_NUM_LOG-1:0] alloc_tag,
  input  logic                   st_wen,
  input  logic                   st_rdy,
  input  logic [TAG_NUM_LOG-1:0] st_tag,
  input  logic                   st_last,
  output logic                   fetch_ren,
  output logic [TAG_NUM_LOG-1:0] fetch_tag,
  input  logic [DATA_W-1:0]      fetch_data,
  input  logic                   fetch_last,
  input  logic                   fetch_vld,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [DATA_W-1:0]      out_data,
  output logic [TAG_NUM_LOG-1:0] out_tag,
  output logic                   out_last,
  output logic [TAG_NUM_LOG:0]   outstanding,
  output logic [2:0]             err
);

  localparam int L  = TAG_NUM_LOG;
  localparam int FW = L + 1 + DATA_W;
  localparam logic [L:0]            TAG_NUM_V  = TAG_NUM[L:0];
  localparam logic [BEAT_CNT_W-1:0] BEAT_MAX_V = BEAT_MAX[BEAT_CNT_W-1:0];

  logic [L:0]            alloc_ptr_q, alloc_ptr_d;
  logic [L:0]            head_ptr_q, head_ptr_d;
  logic                  done_q [TAG_NUM];
  logic                  done_d [TAG_NUM];
  logic [BEAT_CNT_W-1:0] beats_q [TAG_NUM];
  logic [BEAT_CNT_W-1:0] beats_d [TAG_NUM];
  logic [0:0]            state_q, state_d;
  logic [BEAT_CNT_W-1:0] remain_q, remain_d;
  logic                  inflight_q, inflight_last_q;
  logic [L-1:0]          inflight_tag_q;
  logic [2:0]            err_q, err_d;

  logic [L-1:0] head_tag, st_offset;
  logic         alloc_fire, st_acc, st_is_out, pop, ren_last;
  logic [1:0]   occ;
  logic [FW-1:0] fifo_head;

  assign head_tag    = head_ptr_q[L-1:0];
  assign outstanding = alloc_ptr_q - head_ptr_q;
  assign alloc_gnt   = outstanding < TAG_NUM_V;
  assign alloc_tag   = alloc_ptr_q[L-1:0];
  assign alloc_fire  = alloc_req & alloc_gnt;
  assign st_acc      = st_wen & st_rdy;
  // A tag is live when its ring distance from head is below the live count.
  assign st_offset   = st_tag - head_tag;
  assign st_is_out   = {1'b0, st_offset} < outstanding;
  assign pop         = out_vld & out_rdy;
  assign fetch_tag   = head_tag;
  assign err         = err_q;

  always_comb begin
    alloc_ptr_d = alloc_ptr_q + {{L{1'b0}}, alloc_fire};
    head_ptr_d  = head_ptr_q;
    done_d      = done_q;
    beats_d     = beats_q;
    state_d     = state_q;
    remain_d    = remain_q;
    err_d       = err_q;
    fetch_ren   = 1'b0;
    ren_last    = 1'b0;

    if (st_acc) begin
      if (!st_is_out) begin
        err_d[ERR_STRAY_STORE] = 1'b1;
      end else begin
        if (beats_q[st_tag] == BEAT_MAX_V) err_d[ERR_BEAT_OVERFLOW] = 1'b1;
        else                               beats_d[st_tag] = beats_q[st_tag] + 1'b1;
        if (st_last) done_d[st_tag] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (outstanding != '0 && done_q[head_tag]) begin
          remain_d = beats_q[head_tag];
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Count beats already committed to the FIFO so a stall never overfills it.
        fetch_ren = ({1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;
        if (fetch_ren) begin
          remain_d = remain_q - 1'b1;
          if (remain_q <= 4'd1) begin
            ren_last         = 1'b1;
            done_d[head_tag]  = 1'b0;
            beats_d[head_tag] = '0;
            head_ptr_d        = head_ptr_q + 1'b1;
            state_d           = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fetch_vld && (fetch_last != inflight_last_q)) err_d[ERR_LAST_MISMATCH] = 1'b1;
  end

  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q     <= '0;
      head_ptr_q      <= '0;
      state_q         <= ST_IDLE;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_tag_q  <= '0;
      err_q           <= '0;
      for (int t = 0; t < TAG_NUM; t++) begin
        done_q[t]  <= 1'b0;
        beats_q[t] <= '0;
      end
    end else begin
      alloc_ptr_q     <= alloc_ptr_d;
      head_ptr_q      <= head_ptr_d;
      state_q         <= state_d;
      remain_q        <= remain_d;
      inflight_q      <= fetch_ren;
      inflight_last_q <= ren_last;
      inflight_tag_q  <= head_tag;
      err_q           <= err_d;
      done_q          <= done_d;
      beats_q         <= beats_d;
    end
  end

  rsp_skid_fifo #(.W(FW)) u_rsp_fifo (
    .dma_clk   (dma_clk),
    .rst_n     (rst_n),
    .push      (fetch_vld),
    .push_data ({inflight_tag_q, inflight_last_q, fetch_data}),
    .pop       (pop),
    .occ       (occ),
    .head      (fifo_head)
  );

  assign out_vld                    = occ != 2'd0;
  assign {out_tag, out_last, out_data} = fifo_head;

endmodule

// File: tb/tb_dma_rd_reorder_ctrl.sv
// Randomized scoreboard bench for dma_rd_reorder_ctrl; the bench also plays
// the tag buffer, answering every fetch one cycle later.
module tb_dma_rd_reorder_ctrl;
  import dma_rd_pkg::*;

  logic                   dma_clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   alloc_req = 1'b0, alloc_gnt;
  logic [TAG_NUM_LOG-1:0] alloc_tag;
  logic                   st_wen = 1'b0, st_rdy = 1'b0, st_last = 1'b0;
  logic [TAG_NUM_LOG-1:0] st_tag = '0;
  logic                   fetch_ren;
  logic [TAG_NUM_LOG-1:0] fetch_tag;
  logic [DATA_W-1:0]      fetch_data = '0;
  logic                   fetch_last = 1'b0, fetch_vld = 1'b0;
  logic                   out_vld, out_rdy = 1'b0, out_last;
  logic [DATA_W-1:0]      out_data;
  logic [TAG_NUM_LOG-1:0] out_tag;
  logic [TAG_NUM_LOG:0]   outstanding;
  logic [2:0]             err;

  dma_rd_reorder_ctrl #(
    .TAG_NUM(TAG_NUM), .TAG_NUM_LOG(TAG_NUM_LOG), .DATA_W(DATA_W), .BEAT_MAX(BEAT_MAX)
  ) dut (
    .dma_clk(dma_clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_tag(alloc_tag), .st_wen(st_wen), .st_rdy(st_rdy), .st_tag(st_tag),
    .st_last(st_last), .fetch_ren(fetch_ren), .fetch_tag(fetch_tag),
    .fetch_data(fetch_data), .fetch_last(fetch_last), .fetch_vld(fetch_vld),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .outstanding(outstanding), .err(err)
  );

  always #5 dma_clk = ~dma_clk;

  typedef struct {
    logic [TAG_NUM_LOG-1:0] tag;
    logic                   last;
    logic [DATA_W-1:0]      data;
  } exp_t;

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  logic [DATA_W-1:0] mem [TAG_NUM][BEAT_MAX];
  int  widx [TAG_NUM], rd_idx [TAG_NUM], tgt [TAG_NUM];
  bit  cmpl [TAG_NUM];
  int  alloc_q[$], open_q[$];
  int  alloc_cnt = 0, deliv_cnt = 0;
  int  rdy_mode = 3;   // 0 random, 1 toggle, 2 held low, 3 held high
  bit  corrupt_en = 0;
  int  corrupt_tag = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a tag's response is min(stored beats, BEAT_MAX) beats, and
  // responses leave strictly in allocation order once the tag has seen its last.
  function automatic int beats_of(input int t);
    return (widx[t] > BEAT_MAX) ? BEAT_MAX : widx[t];
  endfunction

  task automatic flush_completed();
    int t, n;
    exp_t e;
    while (alloc_q.size() != 0 && cmpl[alloc_q[0]]) begin
      t = alloc_q.pop_front();
      n = beats_of(t);
      cmpl[t] = 0;
      for (int i = 0; i < n; i++) begin
        e.tag  = TAG_NUM_LOG'(t);
        e.last = (i == n - 1);
        e.data = mem[t][i];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic model_alloc();
    int t;
    t = alloc_cnt % TAG_NUM;
    alloc_q.push_back(t);
    open_q.push_back(t);
    widx[t] = 0;
    rd_idx[t] = 0;
    tgt[t] = $urandom_range(BEAT_MAX, 1);
    alloc_cnt++;
  endtask

  task automatic model_store(input int t, input bit last, input logic [DATA_W-1:0] d);
    if (widx[t] < BEAT_MAX) mem[t][widx[t]] = d;
    widx[t]++;
    if (last) begin
      cmpl[t] = 1;
      for (int k = 0; k < open_q.size(); k++)
        if (open_q[k] == t) begin
          open_q.delete(k);
          break;
        end
      flush_completed();
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // All driving tasks start and end at posedge + 1.
  task automatic alloc_one();
    alloc_req = 1'b1;
    check("alloc_gnt", alloc_gnt, 1'b1);
    check("alloc_tag", alloc_tag, alloc_cnt % TAG_NUM);
    @(posedge dma_clk); #1;
    alloc_req = 1'b0;
    model_alloc();
  endtask

  task automatic store_raw(input int t, input bit last, input logic [DATA_W-1:0] d);
    bit acc = 0;
    while (!acc) begin
      st_wen = 1'b1; st_tag = TAG_NUM_LOG'(t); st_last = last;
      fetch_data = fetch_data;
      st_rdy = ($urandom_range(3) != 0);
      acc = st_rdy;
      @(posedge dma_clk); #1;
    end
    st_wen = 1'b0; st_rdy = 1'b0; st_last = 1'b0;
  endtask

  task automatic store_beat(input int t, input bit last);
    logic [DATA_W-1:0] d;
    d = rand_data();
    store_raw(t, last, d);
    model_store(t, last, d);
  endtask

  task automatic store_tag(input int t, input int n);
    for (int i = 0; i < n; i++) store_beat(t, i == n - 1);
  endtask

  task automatic wait_drain(input string name);
    int b = 3000;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge dma_clk); #1;
      b--;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(posedge dma_clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_alloc_gnt", alloc_gnt, 1'b1);
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_fetch_ren", fetch_ren, 1'b0);
    check("rst_fetch_tag", fetch_tag, 0);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_req = 1'b0; st_wen = 1'b0; st_rdy = 1'b0; st_last = 1'b0;
    exp_q.delete(); alloc_q.delete(); open_q.delete();
    alloc_cnt = 0; deliv_cnt = 0;
    for (int t = 0; t < TAG_NUM; t++) begin
      cmpl[t] = 0; widx[t] = 0; rd_idx[t] = 0;
    end
    #1;
    check_reset_state();
    repeat (2) @(posedge dma_clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge dma_clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = ($urandom_range(1) == 1);
      1:       out_rdy = !out_rdy;
      2:       out_rdy = 1'b0;
      default: out_rdy = 1'b1;
    endcase
  end

  // Tag-buffer stand-in: a fetch seen in one cycle is answered in the next.
  bit ren_seen = 0;
  int ren_tag = 0;

  task automatic serve(input int t);
    int n, i;
    n = beats_of(t);
    i = rd_idx[t];
    fetch_vld  = 1'b1;
    fetch_data = (i < n) ? mem[t][i] : '0;
    fetch_last = (i == n - 1) ^ (corrupt_en && t == corrupt_tag && i == 0);
    rd_idx[t]  = (i >= n - 1) ? 0 : i + 1;
  endtask

  always @(posedge dma_clk) begin
    #1;
    if (ren_seen && rst_n) serve(ren_tag);
    else begin
      fetch_vld = 1'b0;
      fetch_last = 1'b0;
    end
  end

  // Monitor: scoreboard pops, stall stability and FIFO-occupancy bound.
  int in_pipe = 0;
  bit mon_pop, prev_stall = 0;
  logic [DATA_W-1:0]      prev_data;
  logic [TAG_NUM_LOG-1:0] prev_tag;
  exp_t mon_e;

  always @(negedge dma_clk) begin
    if (!rst_n) begin
      in_pipe = 0; prev_stall = 0; ren_seen = 0;
    end else begin
      mon_pop = out_vld && out_rdy;
      if (prev_stall) begin
        check("stall_vld", out_vld, 1'b1);
        check("stall_data", out_data, prev_data);
        check("stall_tag", out_tag, prev_tag);
      end
      prev_stall = out_vld && !out_rdy;
      prev_data  = out_data;
      prev_tag   = out_tag;
      if (mon_pop) begin
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_tag", out_tag, mon_e.tag);
          check("out_last", out_last, mon_e.last);
          check("out_data", out_data, mon_e.data);
          if (mon_e.last) deliv_cnt++;
        end
      end
      if (fetch_ren) check("fifo_bound", (in_pipe - int'(mon_pop) + 1) <= 2, 1'b1);
      in_pipe  = in_pipe + int'(fetch_ren) - int'(mon_pop);
      ren_seen = fetch_ren;
      ren_tag  = int'(fetch_tag);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, t;
    bit do_alloc, do_st, last;
    logic [DATA_W-1:0] d;

    #2;
    @(posedge dma_clk); #1;
    do_reset();

    // In-order allocation and out-of-order completion.
    rdy_mode = 3;
    repeat (3) alloc_one();
    check("outstanding_3", outstanding, 3);
    store_tag(1, 2);
    store_tag(0, 3);
    wait_drain("drain_t01");
    check("outstanding_1", outstanding, alloc_cnt - deliv_cnt);

    // Eight beats with a toggling consumer.
    rdy_mode = 1;
    store_tag(2, 8);
    wait_drain("drain_toggle");
    check("outstanding_0", outstanding, 0);

    // Full ring, then free the head tag and reuse it.
    rdy_mode = 3;
    do_reset();
    repeat (TAG_NUM) alloc_one();
    check("gnt_full", alloc_gnt, 1'b0);
    check("outstanding_full", outstanding, TAG_NUM);
    store_tag(0, 2);
    b = 50;
    while (!alloc_gnt && b > 0) begin
      @(posedge dma_clk); #1;
      b--;
    end
    check("gnt_reopen", alloc_gnt, 1'b1);
    check("outstanding_63", outstanding, TAG_NUM - 1);
    check("reuse_tag", alloc_tag, 0);
    wait_drain("drain_full0");
    alloc_one();

    // Random interleaved stores, allocations and consumer stalls.
    rdy_mode = 0;
    b = 80;
    for (int cyc = 0; cyc < 6000 && (open_q.size() != 0 || b > 0); cyc++) begin
      do_alloc = (b > 0) && (alloc_cnt - deliv_cnt < TAG_NUM) && ($urandom_range(1) == 1);
      alloc_req = do_alloc;
      if (do_alloc) begin
        check("rnd_alloc_gnt", alloc_gnt, 1'b1);
        check("rnd_alloc_tag", alloc_tag, alloc_cnt % TAG_NUM);
      end
      do_st = (open_q.size() != 0) && ($urandom_range(3) != 0);
      t = 0; last = 0; d = '0;
      if (do_st) begin
        t = open_q[$urandom_range(open_q.size() - 1)];
        last = (widx[t] == tgt[t] - 1);
        d = rand_data();
        st_tag = TAG_NUM_LOG'(t); st_last = last; st_rdy = ($urandom_range(3) != 0);
      end else st_rdy = 1'b0;
      st_wen = do_st;
      @(posedge dma_clk); #1;
      if (do_alloc) begin
        model_alloc();
        b--;
      end
      if (do_st && st_rdy) model_store(t, last, d);
      st_wen = 1'b0; st_rdy = 1'b0; alloc_req = 1'b0;
    end
    check("rnd_all_stored", open_q.size(), 0);
    wait_drain("drain_random");
    check("outstanding_rnd", outstanding, alloc_cnt - deliv_cnt);

    // Stray store to the next unallocated tag, then use that tag normally.
    rdy_mode = 3;
    t = alloc_cnt % TAG_NUM;
    store_raw(t, 1'b1, rand_data());
    check("err_stray", err, 3'b010);
    alloc_one();
    store_tag(t, 2);
    wait_drain("drain_after_stray");

    // Ninth beat overflows and is dropped; the tag still drains eight beats.
    t = alloc_cnt % TAG_NUM;
    alloc_one();
    for (int i = 0; i < BEAT_MAX; i++) store_beat(t, 1'b0);
    check("err_no_ovf_yet", err, 3'b010);
    store_beat(t, 1'b1);
    check("err_overflow", err, 3'b011);
    wait_drain("drain_overflow");

    // Buffer reports a wrong last flag; data still flows.
    t = alloc_cnt % TAG_NUM;
    corrupt_tag = t; corrupt_en = 1;
    alloc_one();
    store_tag(t, 2);
    wait_drain("drain_mismatch");
    corrupt_en = 0;
    check("err_mismatch", err, 3'b111);

    // Reset in the middle of a stalled drain.
    rdy_mode = 2;
    t = alloc_cnt % TAG_NUM;
    alloc_one();
    store_tag(t, 8);
    repeat (12) @(posedge dma_clk);
    #1;
    check("stalled_vld", out_vld, 1'b1);
    do_reset();
    rdy_mode = 3;
    check("post_rst_vld", out_vld, 1'b0);
    check("post_rst_outstanding", outstanding, 0);
    alloc_one();
    store_tag(0, 1);
    wait_drain("drain_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_rd_reorder_ctrl.md
# dma_rd_reorder_ctrl

Sequencer for the DMA-read reorder tag buffer. It allocates read tags in order, snoops the buffer's store channel to learn when each tag's response is complete, and drains completed tags strictly in allocation order through the buffer's fetch port. Drained data goes to a valid/ready response stream. It sits between the read-request issuer, the tag buffer and the DMA read response consumer.

## Interface
Parameters:
- TAG_NUM, 64, number of read tags (power of 2)
- TAG_NUM_LOG, 6, log2(TAG_NUM)
- DATA_W, 256, beat width
- BEAT_MAX, 8, max beats stored per tag

Ports:
- dma_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_req  in  1  request a tag
- alloc_gnt  out  1  tag available; allocation occurs on alloc_req & alloc_gnt
- alloc_tag  out  TAG_NUM_LOG  tag granted
- st_wen  in  1  snooped store_wen
- st_rdy  in  1  snooped store_rdy; beat accepted on st_wen & st_rdy
- st_tag  in  TAG_NUM_LOG  snooped store_tag
- st_last  in  1  snooped store_last; marks the final beat of the tag
- fetch_ren  out  1  fetch request to tag buffer
- fetch_tag  out  TAG_NUM_LOG  tag fetched
- fetch_data  in  DATA_W  fetched beat
- fetch_last  in  1  last flag of fetched beat
- fetch_vld  in  1  fetched beat valid, exactly 1 cycle after fetch_ren
- out_vld  out  1  response beat valid
- out_rdy  in  1  consumer ready
- out_data  out  DATA_W  response beat
- out_tag  out  TAG_NUM_LOG  tag of beat
- out_last  out  1  final beat of tag
- outstanding  out  TAG_NUM_LOG+1  allocated, not yet drained tags
- err  out  3  sticky {last_mismatch, stray_store, beat_overflow}

## Operation
- Tags are allocated as a ring. alloc_ptr and head_ptr are TAG_NUM_LOG+1 bits wide. outstanding = alloc_ptr - head_ptr. alloc_gnt = outstanding < TAG_NUM. alloc_tag = alloc_ptr[TAG_NUM_LOG-1:0] (combinational).
- Per-tag state: beats[t] (4 bits) counts accepted store beats. done[t] is set when the accepted beat carries st_last.
- If a store targets a tag that is not outstanding, it is ignored and sets err[1].
- A store beyond BEAT_MAX sets err[0]. The beat is not counted and beats saturates.
- FSM IDLE: if outstanding != 0 and done[head], latch remain = beats[head] and go to DRAIN.
- FSM DRAIN: fetch_ren = (occ + inflight - pop) < 2, with fetch_tag = head.
  - occ is the output FIFO occupancy (0..2). inflight is the fetch_ren of the previous cycle. pop = out_vld & out_rdy.
  - Each ren decrements remain. The ren issued with remain == 1 is tagged last.
  - After that final ren: clear done[head] and beats[head], increment head_ptr, return to IDLE.
- fetch_vld pushes {tag, last, fetch_data} into the 2-entry output FIFO. Here last is the controller's own tag, not fetch_last.
- If fetch_last != controller last on a fetch_vld, set err[2]. The data is still forwarded.
- out_* present the FIFO head. Holding out_rdy low stalls fetching with no loss.
- Free and allocate in the same cycle: outstanding is unchanged.
- A store to the head tag in the same cycle IDLE samples it: IDLE sees the update next cycle.
- Freed tag reuse: a tag is reallocatable the cycle after head increments. Its beats in the FIFO remain valid.

## Timing
- Reset values:
  - alloc_gnt = 1, alloc_tag = 0, outstanding = 0
  - fetch_ren = 0, fetch_tag = 0
  - out_vld = 0, out_last = 0, out_tag = 0, out_data = 0
  - err = 0
  - all done/beats = 0, FSM = IDLE
- A reset mid-drain discards FIFO contents and all tag state.
- Latency: st_last accepted at t → done visible t+1 → IDLE latches t+1 → first fetch_ren t+2 → fetch_vld t+3 → out_vld t+4.
- Throughput is 1 beat/cycle with out_rdy held high.
- There is one IDLE bubble cycle between consecutive tags.
- out_* are stable while out_vld & !out_rdy.

## Structure
- Shared package `dma_rd_pkg`:
  - TAG_NUM, TAG_NUM_LOG, DATA_W, BEAT_MAX
  - FSM state enum (IDLE, DRAIN)
  - err bit indices
- Sub-module `rsp_skid_fifo`: a 2-entry synchronous FIFO of {tag, last, data}, with push, pop, occ and head outputs.

## Test plan
- Reset, then alloc_req for 3 cycles → alloc_tag 0, 1, 2; outstanding = 3.
- Store tag 1 with 2 beats, then tag 0 with 3 beats (last on final beat), out_rdy = 1 → out delivers tag 0 (3 beats, out_last on the 3rd), then tag 1 (2 beats); outstanding = 1.
- Allocate 64 tags → alloc_gnt = 0. Complete tag 0 → alloc_gnt = 1 the cycle after head increments; the next alloc_tag is 0.
- Drain 8 beats with out_rdy toggling 1/0 each cycle → 8 beats in order, none lost or duplicated, fetch_ren never raises occ above 2.
- Store to a non-outstanding tag → err[1] = 1; beats of that tag unchanged. A 9th store beat → err[0] = 1.
- Reset asserted mid-DRAIN → next cycle out_vld = 0, outstanding = 0, FSM = IDLE; a subsequent allocation returns tag 0.
